execute_stage: RTL and testbench
================================

// Module: execute_stage
// PURPOSE
//  EXE stage of the 5-stage ARM pipeline: consumes the ID->EXE register outputs, forms the second operand,
//  runs the ALU, owns the NZCV status register and the EXE->MEM pipeline register.
//  Drives branchTaken/branchAddress back to InstructionFetch (branchTaken doubles as the pipeline flush)
//  and N/Z/C/V back to InstructionDecode for condition evaluation.
// PARAMETERS
//  WIDTH  32  datapath width; only 32 is supported (rotate/shift encodings assume it).
// PORTS
//  clk               in   1   clock; all state updates on posedge.
//  rst               in   1   synchronous, active-high reset.
//  writeBackEn, memRead, memWrite, s, branch  in 1 each   control bits from ID->EXE register.
//  executeCommand    in   4   ALU opcode.
//  PC                in   32  instruction address + 4.
//  reg1Val, reg2Val  in   32  Rn and Rm/Rd register values.
//  immediate         in   1   I bit.
//  shiftOperand      in   12  shifter_operand / memory offset field.
//  signedImmediate   in   24  branch offset.
//  destination       in   4   Rd.
//  branchTaken       out  1   combinational = branch; also the flush for IF->ID and ID->EXE.
//  branchAddress     out  32  combinational PC + (signext(signedImmediate) << 2), mod 2^32.
//  N, Z, C, V        out  1   status register contents.
//  writeBackEnMEM, memReadMEM, memWriteMEM  out 1   registered controls.
//  aluResultMEM      out  32  registered ALU result / memory address.
//  storeValMEM       out  32  registered reg2Val (STR data).
//  destinationMEM    out  4   registered Rd.
// BEHAVIOUR
//  - Reset: all EXE->MEM outputs 0, N=Z=C=V=0. Reset mid-operation discards the in-flight instruction
//    and its pending status write; branchTaken/branchAddress stay combinational and unaffected.
//  - Val2: if memRead|memWrite -> zero-extend shiftOperand[11:0]. Else if immediate -> {24'b0,
//    shiftOperand[7:0]} rotated right by 2*shiftOperand[11:8] (rotate 0 = unrotated).
//    Else reg2Val shifted by shiftOperand[11:7] with type shiftOperand[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR;
//    shift amount 0 passes reg2Val unchanged for all types. Shifter carry-out is not used.
//  - ALU (Val1 = reg1Val, Cin = current C): 0001 MOV Val2; 1001 MVN ~Val2; 0010 ADD Val1+Val2;
//    0011 ADC Val1+Val2+Cin; 0100 SUB/CMP Val1-Val2; 0101 SBC Val1-Val2-~Cin; 0110 AND/TST;
//    0111 ORR; 1000 EOR; any other code -> result 0, flags N/Z from result, C=V=0.
//  - Flags: N=result[31], Z=(result==0). Add: C=carry out of bit 31, V=signed overflow.
//    Subtract: C = NOT borrow, V=signed overflow. Logic/MOV/MVN: C and V keep current value.
//  - Status register written at posedge iff s=1 and rst=0; ID sees new flags the following cycle.
//    A flushed bubble carries s=0 so it never writes flags.
//  - EXE->MEM register: latency 1 cycle, loaded every cycle (no stall input); bubbles propagate as all-zero controls.
//  - Branch: no condition check here (done in ID); branch with s=1 still updates flags per ALU result.
//  - Wrap-around: all adds modulo 2^32; branchAddress wraps silently.
// STRUCTURE
//  - Shared package arm_defs: executeCommand encodings (EXE_MOV..EXE_EOR), shift-type codes, WIDTH.
//  - One sub-module: val2_generator (pure combinational, ports shiftOperand, immediate, isMem, reg2Val -> val2).
//  - ALU, status register and EXE->MEM register stay in execute_stage.
// TESTING
//  1. ADD reg1=0x7FFFFFFF, Val2=imm 1, s=1 -> aluResultMEM=0x80000000 next cycle; N=1,Z=0,C=0,V=1.
//  2. SUB reg1=5, reg2=5, LSL #0, s=1 -> result 0; Z=1, C=1, V=0, N=0.
//  3. MOV immediate, shiftOperand=0x4FF (rot 4 -> ror 8) -> aluResultMEM=0xFF000000; s=0 -> flags unchanged.
//  4. ASR reg2=0x80000000 by 4 (shiftOperand=0x240) -> Val2=0xF8000000; ROR reg2=0x1 by 1 -> 0x80000000.
//  5. LDR reg1=0x100, shiftOperand=0x004, memRead=1 -> aluResultMEM=0x104, memReadMEM=1, destinationMEM=Rd.
//  6. branch=1, PC=0x20, signedImmediate=0xFFFFFE -> branchTaken=1, branchAddress=0x18 same cycle;
//     then assert rst with s=1 on next instruction -> all outputs 0, flags stay 0.

Source files
------------

// File: rtl/arm_defs_pkg.sv
// Shared definitions for the ARM EXE stage: datapath width, ALU opcode
// encodings, shifter type codes and a rotate-right helper.
package arm_defs;

    localparam int WIDTH = 32;

    typedef enum logic [3:0] {
        EXE_NOP = 4'b0000,
        EXE_MOV = 4'b0001,
        EXE_ADD = 4'b0010,
        EXE_ADC = 4'b0011,
        EXE_SUB = 4'b0100,
        EXE_SBC = 4'b0101,
        EXE_AND = 4'b0110,
        EXE_ORR = 4'b0111,
        EXE_EOR = 4'b1000,
        EXE_MVN = 4'b1001
    } exe_cmd_e;

    typedef enum logic [1:0] {
        SHIFT_LSL = 2'b00,
        SHIFT_LSR = 2'b01,
        SHIFT_ASR = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_type_e;

    // Rotate right by 0..31; the left-shift term becomes a shift by 32
    // (all zeros) when amt is 0, so amt=0 returns the value unchanged.
    function automatic logic [WIDTH-1:0] ror32(input logic [WIDTH-1:0] val,
                                               input logic [4:0]       amt);
        logic [5:0] inv_amt;
        inv_amt = 6'd32 - {1'b0, amt};
        return (val >> amt) | (val << inv_amt);
    endfunction

endpackage

// File: rtl/val2_generator.sv
// Second-operand former for the EXE stage (pure combinational).
// Ports:
//   shiftOperand  in  12  shifter_operand / memory offset field
//   immediate     in   1  I bit
//   isMem         in   1  load/store: use zero-extended 12-bit offset
//   reg2Val       in  32  Rm value
//   val2          out 32  second ALU operand
module val2_generator
    import arm_defs::*;
(
    input  logic [11:0]      shiftOperand,
    input  logic             immediate,
    input  logic             isMem,
    input  logic [WIDTH-1:0] reg2Val,
    output logic [WIDTH-1:0] val2
);

    logic [4:0]       rot_amt;
    logic [4:0]       sh_amt;
    logic [1:0]       sh_type;
    logic [WIDTH-1:0] imm_ext;
    logic [WIDTH-1:0] asr_val;

    always_comb begin
        rot_amt = {shiftOperand[11:8], 1'b0};
        sh_amt  = shiftOperand[11:7];
        sh_type = shiftOperand[6:5];
        imm_ext = {24'b0, shiftOperand[7:0]};
        asr_val = $unsigned($signed(reg2Val) >>> sh_amt);
        val2    = reg2Val;

        if (isMem) begin
            val2 = {20'b0, shiftOperand};
        end else if (immediate) begin
            val2 = ror32(imm_ext, rot_amt);
        end else if (sh_amt != 5'd0) begin
            case (sh_type)
                SHIFT_LSL: val2 = reg2Val << sh_amt;
                SHIFT_LSR: val2 = reg2Val >> sh_amt;
                SHIFT_ASR: val2 = asr_val;
                default:   val2 = ror32(reg2Val, sh_amt);
            endcase
        end
    end

endmodule

// File: rtl/execute_stage.sv
// EXE stage of the 5-stage ARM pipeline: forms Val2, runs the ALU, holds the
// NZCV status register and the EXE->MEM pipeline register, and reports the
// branch target back to fetch.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   writeBackEn..branch          control bits from the ID->EXE register
//   executeCommand               ALU opcode
//   PC, reg1Val, reg2Val         PC+4, Rn, Rm/Rd values
//   immediate, shiftOperand      operand-2 selection fields
//   signedImmediate              24-bit branch offset (words)
//   destination                  Rd
//   branchTaken, branchAddress   combinational branch/flush to fetch
//   N, Z, C, V                   status register contents
//   *MEM                         registered EXE->MEM outputs
module execute_stage
    import arm_defs::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             writeBackEn,
    input  logic             memRead,
    input  logic             memWrite,
    input  logic             s,
    input  logic             branch,
    input  logic [3:0]       executeCommand,
    input  logic [WIDTH-1:0] PC,
    input  logic [WIDTH-1:0] reg1Val,
    input  logic [WIDTH-1:0] reg2Val,
    input  logic             immediate,
    input  logic [11:0]      shiftOperand,
    input  logic [23:0]      signedImmediate,
    input  logic [3:0]       destination,
    output logic             branchTaken,
    output logic [WIDTH-1:0] branchAddress,
    output logic             N,
    output logic             Z,
    output logic             C,
    output logic             V,
    output logic             writeBackEnMEM,
    output logic             memReadMEM,
    output logic             memWriteMEM,
    output logic [WIDTH-1:0] aluResultMEM,
    output logic [WIDTH-1:0] storeValMEM,
    output logic [3:0]       destinationMEM
);

    logic [WIDTH-1:0] val2;
    logic [WIDTH-1:0] result;
    logic [WIDTH:0]   sum;
    logic             n_new, z_new, c_new, v_new;

    logic [3:0]       nzcv_d, nzcv_q;
    logic             wb_d, wb_q, mr_d, mr_q, mw_d, mw_q;
    logic [WIDTH-1:0] res_d, res_q, store_d, store_q;
    logic [3:0]       dest_d, dest_q;

    val2_generator u_val2 (
        .shiftOperand (shiftOperand),
        .immediate    (immediate),
        .isMem        (memRead | memWrite),
        .reg2Val      (reg2Val),
        .val2         (val2)
    );

    assign branchTaken   = branch;
    assign branchAddress = PC + {{6{signedImmediate[23]}}, signedImmediate, 2'b00};

    always_comb begin
        sum    = '0;
        result = '0;
        c_new  = nzcv_q[1];
        v_new  = nzcv_q[0];
        case (executeCommand)
            EXE_MOV: result = val2;
            EXE_MVN: result = ~val2;
            EXE_ADD, EXE_ADC: begin
                sum = {1'b0, reg1Val} + {1'b0, val2};
                if (executeCommand == EXE_ADC) sum = sum + {{WIDTH{1'b0}}, nzcv_q[1]};
                result = sum[WIDTH-1:0];
                c_new  = sum[WIDTH];
                v_new  = (reg1Val[31] == val2[31]) && (result[31] != reg1Val[31]);
            end
            // Subtract as a + ~b + carry-in so the carry out is NOT borrow.
            EXE_SUB, EXE_SBC: begin
                sum = {1'b0, reg1Val} + {1'b0, ~val2};
                sum = sum + ((executeCommand == EXE_SUB) ? {{WIDTH{1'b0}}, 1'b1}
                                                         : {{WIDTH{1'b0}}, nzcv_q[1]});
                result = sum[WIDTH-1:0];
                c_new  = sum[WIDTH];
                v_new  = (reg1Val[31] != val2[31]) && (result[31] != reg1Val[31]);
            end
            EXE_AND: result = reg1Val & val2;
            EXE_ORR: result = reg1Val | val2;
            EXE_EOR: result = reg1Val ^ val2;
            default: begin
                result = '0;
                c_new  = 1'b0;
                v_new  = 1'b0;
            end
        endcase
        n_new = result[31];
        z_new = (result == '0);

        nzcv_d  = s ? {n_new, z_new, c_new, v_new} : nzcv_q;
        wb_d    = writeBackEn;
        mr_d    = memRead;
        mw_d    = memWrite;
        res_d   = result;
        store_d = reg2Val;
        dest_d  = destination;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            nzcv_q  <= '0;
            wb_q    <= 1'b0;
            mr_q    <= 1'b0;
            mw_q    <= 1'b0;
            res_q   <= '0;
            store_q <= '0;
            dest_q  <= '0;
        end else begin
            nzcv_q  <= nzcv_d;
            wb_q    <= wb_d;
            mr_q    <= mr_d;
            mw_q    <= mw_d;
            res_q   <= res_d;
            store_q <= store_d;
            dest_q  <= dest_d;
        end
    end

    assign {N, Z, C, V}    = nzcv_q;
    assign writeBackEnMEM  = wb_q;
    assign memReadMEM      = mr_q;
    assign memWriteMEM     = mw_q;
    assign aluResultMEM    = res_q;
    assign storeValMEM     = store_q;
    assign destinationMEM  = dest_q;

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        writeBackEn, memRead, memWrite, s, branch;
    logic [3:0]  executeCommand;
    logic [31:0] PC, reg1Val, reg2Val;
    logic        immediate;
    logic [11:0] shiftOperand;
    logic [23:0] signedImmediate;
    logic [3:0]  destination;
    logic        branchTaken;
    logic [31:0] branchAddress;
    logic        N, Z, C, V;
    logic        writeBackEnMEM, memReadMEM, memWriteMEM;
    logic [31:0] aluResultMEM, storeValMEM;
    logic [3:0]  destinationMEM;

    int total = 0;
    int bad   = 0;

    execute_stage dut (
        .clk             (clk),
        .rst             (rst),
        .writeBackEn     (writeBackEn),
        .memRead         (memRead),
        .memWrite        (memWrite),
        .s               (s),
        .branch          (branch),
        .executeCommand  (executeCommand),
        .PC              (PC),
        .reg1Val         (reg1Val),
        .reg2Val         (reg2Val),
        .immediate       (immediate),
        .shiftOperand    (shiftOperand),
        .signedImmediate (signedImmediate),
        .destination     (destination),
        .branchTaken     (branchTaken),
        .branchAddress   (branchAddress),
        .N               (N),
        .Z               (Z),
        .C               (C),
        .V               (V),
        .writeBackEnMEM  (writeBackEnMEM),
        .memReadMEM      (memReadMEM),
        .memWriteMEM     (memWriteMEM),
        .aluResultMEM    (aluResultMEM),
        .storeValMEM     (storeValMEM),
        .destinationMEM  (destinationMEM)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  cmd;
        logic        mr;
        logic        mw;
        logic        imm;
        logic        sf;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [11:0] sh;
        logic [31:0] exp_res;
        logic [3:0]  exp_nzcv;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        writeBackEn = 0; memRead = 0; memWrite = 0; s = 0; branch = 0;
        executeCommand = 4'h0; PC = 0; reg1Val = 0; reg2Val = 0;
        immediate = 0; shiftOperand = 0; signedImmediate = 0; destination = 0;
    endtask

    task automatic check_mem_zero(input string tag);
        check({tag, " wbMEM"},   {31'b0, writeBackEnMEM}, 32'd0);
        check({tag, " mrMEM"},   {31'b0, memReadMEM},     32'd0);
        check({tag, " mwMEM"},   {31'b0, memWriteMEM},    32'd0);
        check({tag, " resMEM"},  aluResultMEM,            32'd0);
        check({tag, " storeMEM"}, storeValMEM,            32'd0);
        check({tag, " destMEM"}, {28'b0, destinationMEM}, 32'd0);
        check({tag, " nzcv"},    {28'b0, N, Z, C, V},     32'd0);
    endtask

    initial begin
        // cmd, mr, mw, imm, s, r1, r2, sh, expected result, expected NZCV after
        vecs[0]  = '{4'h2, 0, 0, 1, 1, 32'h7FFFFFFF, 32'h0,        12'h001, 32'h80000000, 4'b1001}; // ADD overflow
        vecs[1]  = '{4'h4, 0, 0, 0, 1, 32'h5,        32'h5,        12'h000, 32'h00000000, 4'b0110}; // SUB equal
        vecs[2]  = '{4'h1, 0, 0, 1, 0, 32'h0,        32'h0,        12'h4FF, 32'hFF000000, 4'b0110}; // MOV imm ror 8
        vecs[3]  = '{4'h1, 0, 0, 0, 1, 32'h0,        32'h80000000, 12'h240, 32'hF8000000, 4'b1010}; // ASR #4
        vecs[4]  = '{4'h1, 0, 0, 0, 0, 32'h0,        32'h00000001, 12'h0E0, 32'h80000000, 4'b1010}; // ROR #1
        vecs[5]  = '{4'h2, 1, 0, 0, 0, 32'h100,      32'h0,        12'h004, 32'h00000104, 4'b1010}; // LDR
        vecs[6]  = '{4'h3, 0, 0, 1, 1, 32'h1,        32'h0,        12'h002, 32'h00000004, 4'b0000}; // ADC cin=1
        vecs[7]  = '{4'h5, 0, 0, 1, 1, 32'd10,       32'h0,        12'h003, 32'h00000006, 4'b0010}; // SBC cin=0
        vecs[8]  = '{4'h6, 0, 0, 0, 1, 32'hF0F0,     32'hFF00,     12'h000, 32'h0000F000, 4'b0010}; // AND keeps C
        vecs[9]  = '{4'h7, 0, 0, 0, 0, 32'h0F,       32'hF0,       12'h000, 32'h000000FF, 4'b0010}; // ORR
        vecs[10] = '{4'h8, 0, 0, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 12'h000, 32'h00000000, 4'b0110}; // EOR zero
        vecs[11] = '{4'h9, 0, 0, 1, 1, 32'h0,        32'h0,        12'h000, 32'hFFFFFFFF, 4'b1010}; // MVN
        vecs[12] = '{4'h1, 0, 0, 0, 0, 32'h0,        32'h80000000, 12'hFA0, 32'h00000001, 4'b1010}; // LSR #31
        vecs[13] = '{4'h1, 0, 0, 0, 0, 32'h0,        32'h12345678, 12'h200, 32'h23456780, 4'b1010}; // LSL #4
        vecs[14] = '{4'h0, 0, 0, 0, 1, 32'h5,        32'h7,        12'h000, 32'h00000000, 4'b0100}; // undefined op
        vecs[15] = '{4'h2, 0, 0, 0, 1, 32'hFFFFFFFF, 32'h1,        12'h000, 32'h00000000, 4'b0110}; // ADD carry out
        vecs[16] = '{4'h4, 0, 0, 0, 1, 32'h80000000, 32'h1,        12'h000, 32'h7FFFFFFF, 4'b0011}; // SUB overflow
        vecs[17] = '{4'h2, 0, 1, 0, 0, 32'h200,      32'hABCD,     12'hFFF, 32'h000011FF, 4'b0011}; // STR max offset
        vecs[18] = '{4'h1, 0, 0, 1, 0, 32'h0,        32'h0,        12'h0AB, 32'h000000AB, 4'b0011}; // imm rot 0
        vecs[19] = '{4'h1, 0, 0, 1, 0, 32'h0,        32'h0,        12'hF01, 32'h00000004, 4'b0011}; // imm rot 15

        drive_idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        check_mem_zero("reset");
        rst = 0;

        for (int i = 0; i < NV; i++) begin
            executeCommand = vecs[i].cmd;
            memRead        = vecs[i].mr;
            memWrite       = vecs[i].mw;
            immediate      = vecs[i].imm;
            s              = vecs[i].sf;
            reg1Val        = vecs[i].r1;
            reg2Val        = vecs[i].r2;
            shiftOperand   = vecs[i].sh;
            writeBackEn    = i[0];
            destination    = i[3:0];
            @(posedge clk);
            #1;
            check($sformatf("v%0d result", i), aluResultMEM, vecs[i].exp_res);
            check($sformatf("v%0d nzcv", i), {28'b0, N, Z, C, V}, {28'b0, vecs[i].exp_nzcv});
            check($sformatf("v%0d mrMEM", i), {31'b0, memReadMEM}, {31'b0, vecs[i].mr});
            check($sformatf("v%0d mwMEM", i), {31'b0, memWriteMEM}, {31'b0, vecs[i].mw});
            check($sformatf("v%0d wbMEM", i), {31'b0, writeBackEnMEM}, {31'b0, i[0]});
            check($sformatf("v%0d destMEM", i), {28'b0, destinationMEM}, {28'b0, i[3:0]});
            check($sformatf("v%0d storeMEM", i), storeValMEM, vecs[i].r2);
        end

        // Flags must not change before the clock edge (current NZCV = 0011).
        drive_idle();
        executeCommand = 4'h2; reg1Val = 32'h7FFFFFFF; immediate = 1; shiftOperand = 12'h001; s = 1;
        #2;
        check("pre-edge nzcv", {28'b0, N, Z, C, V}, 32'h3);
        @(posedge clk);
        #1;
        check("post-edge nzcv", {28'b0, N, Z, C, V}, 32'h9);

        // Branch target is combinational, including negative offset and wrap.
        drive_idle();
        branch = 1; PC = 32'h20; signedImmediate = 24'hFFFFFE;
        #1;
        check("branchTaken", {31'b0, branchTaken}, 32'd1);
        check("branchAddress back", branchAddress, 32'h18);
        PC = 32'hFFFFFFFC; signedImmediate = 24'h000002;
        #1;
        check("branchAddress wrap", branchAddress, 32'h4);
        PC = 32'h20; signedImmediate = 24'hFFFFFE;

        // Reset during an s=1 instruction discards it and its flag write;
        // branch outputs stay live while reset is asserted.
        @(posedge clk);
        #1;
        rst = 1; s = 1; executeCommand = 4'h2; writeBackEn = 1; memRead = 1;
        reg1Val = 32'hFFFFFFFF; immediate = 1; shiftOperand = 12'h001; destination = 4'hA;
        #1;
        check("rst branchTaken", {31'b0, branchTaken}, 32'd1);
        check("rst branchAddress", branchAddress, 32'h18);
        @(posedge clk);
        #1;
        check_mem_zero("midrst");

        // Flushed bubble after reset: all-zero controls, flags untouched.
        drive_idle();
        rst = 0;
        @(posedge clk);
        #1;
        check_mem_zero("bubble");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
